evict_writeback_buffer: RTL
===========================

Name: evict_writeback_buffer

Overview:
- Downstream of the data array's victim-block output.
- Captures each evicted 128-bit block with its block address into a small FIFO.
- Drains each entry to main memory as four 32-bit write beats over a req/ack handshake.
- Exposes a snoop compare so the refill path does not fetch stale data for a line still queued for write-back.

Parameters:
- DEPTH, 2, number of buffered victim blocks (power of two, >=2)
- BLK_ADDR_BITS, 28, block address width (byte address [31:4])

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- i_evict_valid  input  1  victim block and address valid this cycle
- i_evict_addr  input  BLK_ADDR_BITS  victim block address {tag,index}
- i_evict_block  input  128  victim block; word n = bits[32n+31:32n]
- o_full  output  1  buffer holds DEPTH entries; upstream must stall
- o_empty  output  1  no entries held and drain FSM idle
- o_mem_wr  output  1  write request to memory
- o_mem_addr  output  32  byte address of current beat
- o_mem_wdata  output  32  data of current beat
- i_mem_ack  input  1  memory accepted current beat
- i_snoop_addr  input  BLK_ADDR_BITS  refill block address to check
- o_snoop_hit  output  1  i_snoop_addr matches a held entry (combinational)
- o_snoop_block  output  128  matching entry data (EVICT_FWD_EN only, else 0)

Behaviour:
- Reset (rst high at posedge): all entries invalid, pointers and count 0, FSM IDLE, beat 0.
  - Outputs after reset: o_mem_wr=0, o_mem_addr=0, o_mem_wdata=0, o_full=0, o_empty=1, o_snoop_hit=0.
  - A partially written block is abandoned, never resumed.
- Push: on posedge with i_evict_valid=1 and o_full=0, write {addr,block} at wr_ptr; wr_ptr++ (wraps mod DEPTH); count++.
  - Push while o_full=1 is ignored; the data is lost, so upstream must honour o_full.
  - o_full is derived from the registered count. A push in the same cycle as the final-beat pop at full is still ignored.
- FSM states IDLE, WRITE:
  - IDLE -> WRITE when count>0. Latch the rd_ptr entry and set beat=0.
  - WRITE: o_mem_wr=1, o_mem_addr={addr,beat[1:0],2'b00}, o_mem_wdata=word[beat]. All are registered and stable until ack.
  - On i_mem_ack with beat<3: beat++, and the next beat is presented the following cycle.
  - On i_mem_ack with beat==3: o_mem_wr=0, rd_ptr++, count--, FSM -> IDLE.
  - This gives a one-cycle idle gap between blocks.
  - i_mem_ack in IDLE is ignored.
- Latency: with ack tied high, a push at cycle 0 gives o_mem_wr high from cycle 2. The four beats occupy cycles 2..5.
- Simultaneous push and pop (not full): both occur; count unchanged.
- o_empty = (count==0) && FSM==IDLE.
- Snoop:
  - o_snoop_hit=1 if any valid entry's addr equals i_snoop_addr, including the entry being drained, until its final ack edge.
  - A push in the current cycle is not visible to the snoop until the next cycle.
  - If multiple entries match, the youngest wins.

Optional Feature:
- EVICT_FWD_EN defined: o_snoop_block returns the youngest matching entry's full 128-bit block, combinationally alongside o_snoop_hit. The refill path may use it instead of waiting for the drain.
- Undefined: o_snoop_block is tied to 128'b0, no data mux is built, and the refill path must stall on o_snoop_hit.

Decomposition:
- Shared package cache_pkg holds:
  - BLOCK_BITS=128, WORD_BITS=32, WORDS_PER_BLOCK=4, OFFSET_BITS=4.
  - The drain FSM state encoding (IDLE, WRITE).
- One sub-module, evict_fifo: entry storage, valid bits, pointers, count, full flag, snoop compare and priority mux.
- evict_writeback_buffer keeps the drain FSM and beat counter.

Test Plan:
- Single evict:
  - Stimulus: addr=28'h0000123, block=128'h44444444_33333333_22222222_11111111, ack always 1.
  - Response: beats addr 0x00001230/34/38/3C with data 11111111, 22222222, 33333333, 44444444 in order; o_empty=1 afterwards.
- Backpressure:
  - Stimulus: ack held low 5 cycles on beat 1.
  - Response: o_mem_addr=0x00001234 and o_mem_wdata=22222222 stay stable for the whole stall; beat 2 follows the ack by one cycle.
- Full:
  - Stimulus: with ack low, push two blocks (A, B), then push C.
  - Response: o_full=1 after B; C is ignored; after release, only A then B are written (8 beats).
- Snoop:
  - Stimulus: hold block 0x0000ABC and snoop 0x0000ABC, then 0x0000ABD.
  - Response: hit=1, then hit=0; the snoop goes to hit=0 the cycle after the final ack of 0x0000ABC.
- Reset mid-drain:
  - Stimulus: assert rst after beat 1 is acked.
  - Response: next cycle o_mem_wr=0, o_empty=1, o_full=0; no further beats issued.
- With EVICT_FWD_EN defined:
  - Stimulus: hold two entries with the same addr (old then new data).
  - Response: o_snoop_block equals the newer data.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions for the victim write-back path.
//   - Block geometry: 128-bit blocks of four 32-bit words, 16-byte blocks.
//   - Drain FSM state encoding (IDLE, WRITE).
//   - block_word(): selects one 32-bit word from a block.
package cache_pkg;

  localparam int BLOCK_BITS      = 128;
  localparam int WORD_BITS       = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_BITS     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  // Word n occupies bits [32n+31:32n].
  function automatic logic [WORD_BITS-1:0] block_word(
    input logic [BLOCK_BITS-1:0] blk,
    input logic [1:0]            idx
  );
    return blk[WORD_BITS*idx +: WORD_BITS];
  endfunction

endpackage

// File: rtl/evict_fifo.sv
// Victim-block storage for the write-back buffer.
// Holds up to DEPTH {block address, 128-bit block} entries in a circular
// buffer with per-entry valid bits, and answers snoop lookups against every
// valid entry (youngest match wins).
//
// Optional feature macro: EVICT_FWD_EN
//   defined   - snoop_block carries the youngest matching entry's data
//   undefined - snoop_block is tied to zero and no data mux is built
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write {push_addr, push_block} if not full
//   push_addr    block address of the victim
//   push_block   victim block data
//   pop          retire the entry at the read pointer
//   full         DEPTH entries held (from registered count)
//   empty        no entries held
//   head_addr    address of the oldest entry
//   head_block   data of the oldest entry
//   snoop_addr   address to look up
//   snoop_hit    some valid entry matches snoop_addr
//   snoop_block  youngest matching entry's data (EVICT_FWD_EN) or zero
module evict_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int BLK_ADDR_BITS = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [BLK_ADDR_BITS-1:0] push_addr,
  input  logic [BLOCK_BITS-1:0]    push_block,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [BLK_ADDR_BITS-1:0] head_addr,
  output logic [BLOCK_BITS-1:0]    head_block,
  input  logic [BLK_ADDR_BITS-1:0] snoop_addr,
  output logic                     snoop_hit,
  output logic [BLOCK_BITS-1:0]    snoop_block
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BLK_ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [BLOCK_BITS-1:0]    blk_mem  [DEPTH];
  logic [DEPTH-1:0]         valid_q;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;

  logic push_ok;
  logic pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push_ok) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      // Push is refused at full, so the write and read slots never coincide here.
      if (pop_ok) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload carries no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      blk_mem[wr_ptr]  <= push_block;
    end
  end

  assign head_addr  = addr_mem[rd_ptr];
  assign head_block = blk_mem[rd_ptr];

  // Scan oldest to youngest from rd_ptr so a later match overrides an earlier one.
`ifdef EVICT_FWD_EN
  logic [PTR_W-1:0] sel;
`endif
  logic [PTR_W-1:0] idx;

  always_comb begin
    snoop_hit = 1'b0;
    idx       = '0;
`ifdef EVICT_FWD_EN
    sel       = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid_q[idx] && (addr_mem[idx] == snoop_addr)) begin
        snoop_hit = 1'b1;
`ifdef EVICT_FWD_EN
        sel       = idx;
`endif
      end
    end
  end

`ifdef EVICT_FWD_EN
  assign snoop_block = snoop_hit ? blk_mem[sel] : '0;
`else
  assign snoop_block = '0;
`endif

endmodule

// File: rtl/evict_writeback_buffer.sv
// Victim write-back buffer.
// Captures evicted 128-bit blocks into evict_fifo and drains each one to
// memory as four 32-bit write beats over a req/ack handshake. Beat address,
// data and request are registered and held stable until acknowledged; a
// one-cycle idle gap separates consecutive blocks.
//
// Optional feature macro: EVICT_FWD_EN (snoop data forwarding, see evict_fifo)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_evict_valid   victim block and address valid this cycle
//   i_evict_addr    victim block address {tag,index}
//   i_evict_block   victim block data
//   o_full          buffer full, upstream must stall
//   o_empty         no entries held and drain idle
//   o_mem_wr        memory write request
//   o_mem_addr      byte address of the current beat
//   o_mem_wdata     data of the current beat
//   i_mem_ack       memory accepted the current beat
//   i_snoop_addr    refill block address to check
//   o_snoop_hit     snoop address matches a held entry
//   o_snoop_block   matching entry data (EVICT_FWD_EN) or zero
module evict_writeback_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int BLK_ADDR_BITS = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_evict_valid,
  input  logic [BLK_ADDR_BITS-1:0] i_evict_addr,
  input  logic [127:0]             i_evict_block,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_mem_wr,
  output logic [31:0]              o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ack,
  input  logic [BLK_ADDR_BITS-1:0] i_snoop_addr,
  output logic                     o_snoop_hit,
  output logic [127:0]             o_snoop_block
);

  logic                     fifo_empty;
  logic [BLK_ADDR_BITS-1:0] head_addr;
  logic [BLOCK_BITS-1:0]    head_block;
  logic                     pop;

  evict_fifo #(
    .DEPTH         (DEPTH),
    .BLK_ADDR_BITS (BLK_ADDR_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (i_evict_valid),
    .push_addr   (i_evict_addr),
    .push_block  (i_evict_block),
    .pop         (pop),
    .full        (o_full),
    .empty       (fifo_empty),
    .head_addr   (head_addr),
    .head_block  (head_block),
    .snoop_addr  (i_snoop_addr),
    .snoop_hit   (o_snoop_hit),
    .snoop_block (o_snoop_block)
  );

  drain_state_t             state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [BLK_ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [BLOCK_BITS-1:0]    cur_block_q, cur_block_d;
  logic                     wr_q, wr_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [1:0]               beat_nx;

  assign beat_nx = beat_q + 2'd1;

  // The entry stays in the FIFO (and snoopable) until its final beat is acked.
  assign pop = (state_q == WRITE) && i_mem_ack && (beat_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cur_addr_d  = cur_addr_q;
    cur_block_d = cur_block_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = WRITE;
          beat_d      = 2'd0;
          cur_addr_d  = head_addr;
          cur_block_d = head_block;
          wr_d        = 1'b1;
          addr_d      = 32'({head_addr, 2'd0, 2'b00});
          wdata_d     = block_word(head_block, 2'd0);
        end
      end
      WRITE: begin
        if (i_mem_ack) begin
          if (beat_q == 2'd3) begin
            state_d = IDLE;
            wr_d    = 1'b0;
          end else begin
            beat_d  = beat_nx;
            addr_d  = 32'({cur_addr_q, beat_nx, 2'b00});
            wdata_d = block_word(cur_block_q, beat_nx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Latched copy of the block being drained; qualified by state_q.
  always_ff @(posedge clk) begin
    cur_addr_q  <= cur_addr_d;
    cur_block_q <= cur_block_d;
  end

  assign o_mem_wr    = wr_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_empty     = fifo_empty && (state_q == IDLE);

endmodule
